// File: rtl/int_ctrl.sv
// Fixed-priority interrupt controller feeding the fetch stage: synchronises, edge-detects and arbitrates 8 lines.
// Optional INT_MASK_EN adds a writable per-line enable mask (mask_we / mask_data).
module int_ctrl #(
    parameter int N_IRQ       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq,
    input  logic             int_ack,
    input  logic             int_done,
`ifdef INT_MASK_EN
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_data,
`endif
    output logic             int_req,
    output logic [2:0]       int_index,
    output logic [N_IRQ-1:0] pending,
    output logic             in_service
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } fsmState_t;

    fsmState_t        state, nextState;
    logic [2:0]       nextIndex;
    logic [N_IRQ-1:0] syncFf [SYNC_STAGES];
    logic [N_IRQ-1:0] hist;
    logic [N_IRQ-1:0] riseEdge;
    logic [N_IRQ-1:0] mask;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] ackClr;
    logic [2:0]       winner;
    logic             anyEligible;

    // NOTE: every flop in the synchroniser array is reset explicitly, so no stale edge survives reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) syncFf[s] <= '0;
            hist <= '0;
        end else begin
            // NOTE: non-blocking assignments make each stage take the previous stage's old value.
            syncFf[0] <= irq;
            for (int s = 1; s < SYNC_STAGES; s++) syncFf[s] <= syncFf[s-1];
            hist <= syncFf[SYNC_STAGES-1];
        end
    end

    assign riseEdge = syncFf[SYNC_STAGES-1] & ~hist;

`ifdef INT_MASK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         mask <= '1;
        else if (mask_we) mask <= mask_data;
    end
`else
    assign mask = '1;
`endif

    assign eligible    = pending & mask;
    assign anyEligible = |eligible;

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        winner = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) winner = i[2:0];
        end
    end

    assign ackClr = (state == REQ && int_ack) ? (N_IRQ'(1) << int_index) : '0;

    // Set is ORed in after the clear so a same-cycle edge keeps the bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pending <= '0;
        else      pending <= (pending & ~ackClr) | riseEdge;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            int_index <= '0;
        end else begin
            state     <= nextState;
            int_index <= nextIndex;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        nextState = state;
        nextIndex = int_index;
        unique case (state)
            IDLE: begin
                if (anyEligible) begin
                    nextIndex = winner;
                    nextState = REQ;
                end
            end
            REQ:     if (int_ack)  nextState = SERVICE;
            SERVICE: if (int_done) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign int_req    = (state == REQ);
    assign in_service = (state == SERVICE);

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: expected grant indices are queued by stimulus and popped by a monitor.
module tb_int_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq;
    logic       int_ack;
    logic       int_done;
    logic       int_req;
    logic [2:0] int_index;
    logic [7:0] pending;
    logic       in_service;
`ifdef INT_MASK_EN
    logic       mask_we;
    logic [7:0] mask_data;
`endif

    int nCompared  = 0;
    int nMismatch  = 0;
    int expQ[$];
    logic       reqSeen = 1'b0;
    logic [2:0] grantIdx = '0;

    int_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .irq        (irq),
        .int_ack    (int_ack),
        .int_done   (int_done),
`ifdef INT_MASK_EN
        .mask_we    (mask_we),
        .mask_data  (mask_data),
`endif
        .int_req    (int_req),
        .int_index  (int_index),
        .pending    (pending),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got running, required finished)");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        nCompared++;
        if (act !== expv) begin
            nMismatch++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: each new request is compared against the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                reqSeen = 1'b0;
            end else if (int_req) begin
                if (!reqSeen) begin
                    reqSeen  = 1'b1;
                    grantIdx = int_index;
                    if (expQ.size() == 0) check("unexpected_grant", 32'(int_index) + 32'h100, 32'hFF);
                    else                  check("grant_index", 32'(int_index), 32'(expQ.pop_front()));
                end else begin
                    check("index_stable", 32'(int_index), 32'(grantIdx));
                end
            end else begin
                reqSeen = 1'b0;
            end
        end
    end

    task automatic waitReq();
        int n = 0;
        while (!int_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!int_req) check("req_timeout", 32'(int_req), 32'd1);
    endtask

    task automatic pulseAck();
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
    endtask

    task automatic pulseDone();
        int_done = 1'b1;
        @(negedge clk);
        int_done = 1'b0;
    endtask

    // Fetch model: optional stray done while requesting and stray ack while in service.
    task automatic serviceOne(input int ackDelay, input int doneDelay);
        waitReq();
        for (int c = 0; c < ackDelay; c++) begin
            int_done = (c == 0);
            @(negedge clk);
            int_done = 1'b0;
        end
        if (ackDelay > 0) check("req_held", 32'(int_req), 32'd1);
        pulseAck();
        check("ack_req_low", 32'(int_req), 32'd0);
        check("ack_in_service", 32'(in_service), 32'd1);
        for (int c = 0; c < doneDelay; c++) begin
            int_ack = (c == 0);
            @(negedge clk);
            int_ack = 1'b0;
        end
        if (doneDelay > 0) check("service_held", 32'(in_service), 32'd1);
        pulseDone();
        check("done_idle", 32'(in_service), 32'd0);
    endtask

    task automatic quiet(input int cycles);
        irq = 8'h00;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        logic [7:0] lines;
        rst      = 1'b0;
        irq      = 8'h00;
        int_ack  = 1'b0;
        int_done = 1'b0;
`ifdef INT_MASK_EN
        mask_we   = 1'b0;
        mask_data = 8'h00;
`endif
        repeat (3) @(negedge clk);
        check("reset_req", 32'(int_req), 32'd0);
        check("reset_index", 32'(int_index), 32'd0);
        check("reset_pending", 32'(pending), 32'h00);
        check("reset_in_service", 32'(in_service), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single held line: exact latency, then no repeat request.
        expQ.push_back(3);
        irq = 8'h08;
        repeat (3) @(negedge clk);
        check("lat_pending_e3", 32'(pending), 32'h08);
        check("lat_req_e3", 32'(int_req), 32'd0);
        @(negedge clk);
        check("lat_req_e4", 32'(int_req), 32'd1);
        check("lat_index_e4", 32'(int_index), 32'd3);
        pulseAck();
        check("single_pending", 32'(pending), 32'h00);
        check("single_in_service", 32'(in_service), 32'd1);
        check("single_req_low", 32'(int_req), 32'd0);
        pulseDone();
        check("single_idle", 32'(in_service), 32'd0);
        repeat (10) @(negedge clk);
        check("held_no_repeat", 32'(int_req), 32'd0);
        quiet(4);

        // Simultaneous lines 4 and 7: priority, then one idle cycle before the next grant.
        expQ.push_back(4);
        expQ.push_back(7);
        irq = 8'h90;
        serviceOne(1, 1);
        check("idle_gap", 32'(int_req), 32'd0);
        @(negedge clk);
        check("regrant_after_gap", 32'(int_req), 32'd1);
        serviceOne(0, 0);
        quiet(4);

        // Frozen grant: a higher-priority edge during REQ waits its turn.
        expQ.push_back(5);
        expQ.push_back(1);
        irq = 8'h20;
        waitReq();
        irq = 8'h22;
        repeat (6) @(negedge clk);
        check("frozen_index", 32'(int_index), 32'd5);
        check("frozen_pending", 32'(pending), 32'h22);
        serviceOne(0, 1);
        serviceOne(2, 0);
        quiet(4);

        // Set/clear collision on line 2.
        expQ.push_back(2);
        expQ.push_back(2);
        irq = 8'h04;
        waitReq();
        quiet(4);
        irq = 8'h04;
        repeat (2) @(negedge clk);
        pulseAck();
        check("collide_pending", 32'(pending[2]), 32'd1);
        check("collide_in_service", 32'(in_service), 32'd1);
        irq = 8'h00;
        pulseDone();
        serviceOne(0, 0);
        quiet(4);

`ifdef INT_MASK_EN
        mask_we   = 1'b1;
        mask_data = 8'hFE;
        @(negedge clk);
        mask_we = 1'b0;
        irq = 8'h01;
        @(negedge clk);
        quiet(6);
        check("masked_pending", 32'(pending), 32'h01);
        check("masked_no_req", 32'(int_req), 32'd0);
        expQ.push_back(0);
        mask_we   = 1'b1;
        mask_data = 8'hFF;
        @(negedge clk);
        mask_we = 1'b0;
        @(negedge clk);
        check("unmask_req", 32'(int_req), 32'd1);
        serviceOne(0, 0);
        quiet(4);
`endif

        // Randomised bursts: all lines pend together, so grants come out in ascending index order.
        for (int it = 0; it < 20; it++) begin
            lines = 8'($urandom_range(1, 255));
            irq = lines;
            for (int i = 0; i < 8; i++) if (lines[i]) expQ.push_back(i);
            repeat ($urandom_range(1, 3)) @(negedge clk);
            irq = 8'h00;
            for (int i = 0; i < $countones(lines); i++) serviceOne($urandom_range(0, 3), $urandom_range(0, 3));
            quiet(4);
            check("burst_drained", 32'(pending), 32'h00);
        end

        // Asynchronous reset in the middle of a request.
        expQ.push_back(0);
        irq = 8'h05;
        waitReq();
        check("pre_reset_pending", 32'(pending), 32'h05);
        #2;
        rst = 1'b0;
        #1;
        check("async_req", 32'(int_req), 32'd0);
        check("async_index", 32'(int_index), 32'd0);
        check("async_pending", 32'(pending), 32'h00);
        check("async_in_service", 32'(in_service), 32'd0);
        irq = 8'h00;
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        check("post_reset_quiet", 32'(int_req), 32'd0);

        check("queue_drained", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Interrupt controller sitting directly upstream of the fetch stage. Synchronises eight asynchronous external interrupt lines, latches rising edges as pending requests, and arbitrates among them by fixed priority. It hands one request at a time to fetch as a vector index plus a req/ack handshake, then holds off further requests until fetch signals that the handler has returned.

## Interface
Parameters:
- N_IRQ, 8, number of interrupt lines; fixed at 8 so the index fits 3 bits.
- SYNC_STAGES, 2, synchroniser depth per line; legal range 2..3.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- irq  in  8  raw external interrupt lines; asynchronous; level-high.
- int_ack  in  1  one-cycle pulse from fetch: vector taken this cycle.
- int_done  in  1  one-cycle pulse from fetch: RTI retired, handler finished.
- mask_we  in  1  mask register write strobe; present only with INT_MASK_EN.
- mask_data  in  8  new mask value, 1 = line enabled; present only with INT_MASK_EN.
- int_req  out  1  request to fetch; drives the fetch interrupt request input.
- int_index  out  3  vector index of the granted line; drives the fetch `index` input.
- pending  out  8  latched, not-yet-acknowledged edges.
- in_service  out  1  high while a handler is running.

## Operation
- Per line: SYNC_STAGES-flop synchroniser, then one history flop. `edge[i] = sync[i] & ~hist[i]`.
- Pending register: bit i is set on `edge[i]` and cleared on int_ack when int_index == i. If set and clear hit the same bit in the same cycle, set wins.
- Eligible vector is `pending & mask`. Without INT_MASK_EN, mask is 8'hFF.
- Priority is fixed: the lowest index wins (line 0 is highest).
- FSM states:
  - IDLE: int_req = 0 and in_service = 0. If the eligible vector is non-zero, latch the winning index into int_index and go to REQ.
  - REQ: int_req = 1 and int_index stays frozen, even if a higher-priority edge arrives. On int_ack, clear that pending bit and go to SERVICE.
  - SERVICE: int_req = 0 and in_service = 1. New edges still latch into pending. On int_done, go to IDLE.
- int_ack outside REQ is ignored. int_done outside SERVICE is ignored.
- No nesting: at most one request is outstanding or in service.
- A line held high produces exactly one request. A new request needs a low period of at least 1 synchronised cycle.
- Reset while in REQ or SERVICE aborts to IDLE and discards all pending edges.

## Timing
- Reset values: int_req = 0, int_index = 3'd0, pending = 8'h00, in_service = 0. All synchroniser and history flops are 0. Mask = 8'hFF.
- Latency with SYNC_STAGES = 2: irq rises and meets setup before edge E1.
  - pending[i] is set at E3.
  - FSM enters REQ and int_req asserts after E4.
- int_ack sampled high at edge Ek: int_req is low and in_service is high after Ek.
- int_done sampled at Ek: FSM is in IDLE after Ek. If other lines are eligible, int_req re-asserts after Ek+1. This gives at least one idle cycle between requests.
- int_index is stable for the whole time int_req is high. Fetch may sample it on any cycle while int_req = 1.

## Configuration
- INT_MASK_EN defined:
  - mask_we and mask_data ports exist.
  - The 8-bit mask register loads mask_data on a clock edge with mask_we = 1.
  - Masked lines still latch into pending but are never granted; unmasking later grants them.
  - A mask write in REQ does not revoke the current request.
- INT_MASK_EN undefined: the ports are absent and all lines are always enabled.

## Test plan
- Reset: rst = 0 mid-REQ with pending = 8'h05 -> all outputs return to their reset values immediately, asynchronously, without waiting for a clock.
- Single line: irq = 8'h08, held -> int_req = 1 after the 4th edge, int_index = 3; ack -> pending = 8'h00, in_service = 1; int_done -> IDLE, no second request while irq is held.
- Priority: irq = 8'h90 in the same cycle -> grant index 4. After ack and done, the next grant is index 7 one idle cycle later.
- Frozen grant: in REQ with index 5, raise irq[1] -> int_index stays 5 until ack. The next grant is 1.
- Set/clear collision: a new edge on line 2 in the same cycle as int_ack for index 2 -> pending[2] = 1 afterwards. A second request on index 2 follows after done.
- INT_MASK_EN: write mask = 8'hFE, then pulse irq[0] -> pending = 8'h01, no int_req. Write mask = 8'hFF -> int_req asserts with int_index = 0 on the second edge after the write.
